// File: rtl/sprite_fetch_arb_if.sv
// Two-port sprite fetch bus: client requests/returns plus the synchronous ROM port.
// master = client/ROM side, slave = arbiter side.
interface sprite_fetch_arb_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 12,
   parameter int ROM_AW = 12
);
   logic              rd0;
   logic              rd1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] base0;
   logic [ADDR_W-1:0] base1;
   logic              ready0;
   logic              ready1;
   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic              valid0;
   logic              valid1;
   logic [ROM_AW-1:0] rom_addr;
   logic [DATA_W-1:0] rom_q;

   modport master (
      output rd0, rd1, addr0, addr1, base0, base1, rom_q,
      input  ready0, ready1, data0, data1, valid0, valid1, rom_addr
   );

   modport slave (
      input  rd0, rd1, addr0, addr1, base0, base1, rom_q,
      output ready0, ready1, data0, data1, valid0, valid1, rom_addr
   );
endinterface

// File: rtl/sprite_fetch_arb.sv
// Round-robin arbiter sharing one sync sprite ROM between two ports: grant at N, rom_addr at N+1, data/valid at N+2.
// A losing request is parked one cycle (ready low); optional counters under SPRITE_FETCH_ARB_STATS_EN.
module sprite_fetch_arb #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 12,
   parameter int ROM_AW = 12
) (
   input  logic                clk,
   input  logic                reset,
   sprite_fetch_arb_if.slave   bus
`ifdef SPRITE_FETCH_ARB_STATS_EN
   ,
   output logic [15:0]         gnt_cnt0,
   output logic [15:0]         gnt_cnt1,
   output logic [15:0]         conflict_cnt
`endif
);

   logic              pend0, pend1;
   logic [ADDR_W-1:0] pend_addr0, pend_addr1;
   logic [ADDR_W-1:0] sum0, sum1;
   logic              last_grant;
   logic              cand0, cand1;
   logic              conflict, gnt, gnt_port;
   logic [ROM_AW-1:0] gnt_addr;
   logic [ROM_AW-1:0] rom_addr_r;
   logic              s1_vld, s1_port, s2_vld, s2_port;
   logic [DATA_W-1:0] hold0, hold1;

   always_comb begin
      sum0     = bus.addr0 + bus.base0;
      sum1     = bus.addr1 + bus.base1;
      cand0    = pend0 | (bus.rd0 & ~pend0);
      cand1    = pend1 | (bus.rd1 & ~pend1);
      conflict = cand0 & cand1;
      gnt      = cand0 | cand1;
      // A parked entry always lost to the other port, so round-robin serves it next cycle.
      gnt_port = conflict ? ~last_grant : cand1;
      gnt_addr = gnt_port ? ROM_AW'(pend1 ? pend_addr1 : sum1)
                          : ROM_AW'(pend0 ? pend_addr0 : sum0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend0      <= 1'b0;
         pend1      <= 1'b0;
         pend_addr0 <= '0;
         pend_addr1 <= '0;
         last_grant <= 1'b1;
         rom_addr_r <= '0;
         s1_vld     <= 1'b0;
         s1_port    <= 1'b0;
         s2_vld     <= 1'b0;
         s2_port    <= 1'b0;
         hold0      <= '0;
         hold1      <= '0;
      end else begin
         pend0 <= conflict & gnt_port;
         pend1 <= conflict & ~gnt_port;
         if (conflict & gnt_port)  pend_addr0 <= sum0;
         if (conflict & ~gnt_port) pend_addr1 <= sum1;
         if (gnt) begin
            last_grant <= gnt_port;
            rom_addr_r <= gnt_addr;
         end
         s1_vld  <= gnt;
         s1_port <= gnt_port;
         s2_vld  <= s1_vld;
         s2_port <= s1_port;
         if (bus.valid0) hold0 <= bus.rom_q;
         if (bus.valid1) hold1 <= bus.rom_q;
      end
   end

   assign bus.ready0   = ~pend0;
   assign bus.ready1   = ~pend1;
   assign bus.rom_addr = rom_addr_r;
   assign bus.valid0   = s2_vld & ~s2_port;
   assign bus.valid1   = s2_vld & s2_port;
   assign bus.data0    = bus.valid0 ? bus.rom_q : hold0;
   assign bus.data1    = bus.valid1 ? bus.rom_q : hold1;

`ifdef SPRITE_FETCH_ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_cnt0     <= '0;
         gnt_cnt1     <= '0;
         conflict_cnt <= '0;
      end else begin
         if (gnt & ~gnt_port) gnt_cnt0 <= gnt_cnt0 + 16'd1;
         if (gnt & gnt_port)  gnt_cnt1 <= gnt_cnt1 + 16'd1;
         if (conflict)        conflict_cnt <= conflict_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sprite_fetch_arb.sv
// Directed + random bench for sprite_fetch_arb against a request/return reference model and a ROM array.
module tb_sprite_fetch_arb;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sprite_fetch_arb_if #(.ADDR_W(12), .DATA_W(12), .ROM_AW(12)) bus ();

`ifdef SPRITE_FETCH_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

   sprite_fetch_arb #(.ADDR_W(12), .DATA_W(12), .ROM_AW(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef SPRITE_FETCH_ARB_STATS_EN
      ,
      .gnt_cnt0     (gnt_cnt0),
      .gnt_cnt1     (gnt_cnt1),
      .conflict_cnt (conflict_cnt)
`endif
   );

   logic [11:0] rom [4096];
   always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

   typedef struct {
      int          cyc;
      int          port;
      logic [11:0] dat;
   } ret_t;

   ret_t        q[$];
   int          tests = 0;
   int          fails = 0;
   int          now = 0;
   bit          m_pend[2];
   logic [11:0] m_paddr[2];
   int          m_last;
   logic [11:0] m_rom_addr;
   logic [11:0] m_data[2];
   int          m_gnt[2];
   int          m_conf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pend[0] = 0;      m_pend[1] = 0;
      m_paddr[0] = '0;    m_paddr[1] = '0;
      m_last = 1;
      m_rom_addr = '0;
      m_data[0] = '0;     m_data[1] = '0;
      m_gnt[0] = 0;       m_gnt[1] = 0;
      m_conf = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      bus.rd0 = 1'b0;
      bus.rd1 = 1'b0;
      #4;
      model_reset();
      chk("rst_ready0", bus.ready0, 1);
      chk("rst_ready1", bus.ready1, 1);
      chk("rst_valid0", bus.valid0, 0);
      chk("rst_valid1", bus.valid1, 0);
      chk("rst_data0", bus.data0, 0);
      chk("rst_data1", bus.data1, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
`ifdef SPRITE_FETCH_ARB_STATS_EN
      chk("rst_gnt_cnt0", gnt_cnt0, 0);
      chk("rst_conflict_cnt", conflict_cnt, 0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // One clock cycle: drive requests, check outputs of this cycle, then advance the model.
   task automatic step(input bit r0, input bit r1, input logic [11:0] a0, input logic [11:0] b0,
                       input logic [11:0] a1, input logic [11:0] b1);
      logic [11:0] ea[2];
      bit          c[2];
      bit          ev[2];
      int          w;
      @(posedge clk); #1;
      now++;
      bus.rd0 = r0; bus.addr0 = a0; bus.base0 = b0;
      bus.rd1 = r1; bus.addr1 = a1; bus.base1 = b1;
      #4;
      ev[0] = 0; ev[1] = 0;
      while (q.size() > 0 && q[0].cyc <= now) begin
         if (q[0].cyc == now) begin
            ev[q[0].port] = 1;
            m_data[q[0].port] = q[0].dat;
         end
         void'(q.pop_front());
      end
      chk("ready0", bus.ready0, !m_pend[0]);
      chk("ready1", bus.ready1, !m_pend[1]);
      chk("valid0", bus.valid0, ev[0]);
      chk("valid1", bus.valid1, ev[1]);
      chk("data0", bus.data0, m_data[0]);
      chk("data1", bus.data1, m_data[1]);
      chk("rom_addr", bus.rom_addr, m_rom_addr);

      ea[0] = m_pend[0] ? m_paddr[0] : 12'(a0 + b0);
      ea[1] = m_pend[1] ? m_paddr[1] : 12'(a1 + b1);
      c[0]  = m_pend[0] || r0;
      c[1]  = m_pend[1] || r1;
      w = -1;
      if (c[0] && c[1]) begin
         w = 1 - m_last;
         m_conf++;
         m_pend[1-w]  = 1;
         m_paddr[1-w] = ea[1-w];
      end else if (c[0]) begin
         w = 0;
      end else if (c[1]) begin
         w = 1;
      end
      if (w >= 0) begin
         m_pend[w]  = 0;
         m_last     = w;
         m_rom_addr = ea[w];
         m_gnt[w]++;
         q.push_back('{now + 2, w, rom[ea[w]]});
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 12'h0, 12'h0, 12'h0, 12'h0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 12'($urandom);
      rom[12'h401] = 12'hABC;
      bus.rd0 = 0; bus.rd1 = 0;
      bus.addr0 = 0; bus.addr1 = 0; bus.base0 = 0; bus.base1 = 0;
      model_reset();
      do_reset();

      // single request with base offset
      step(1, 0, 12'h005, 12'h3FC, 12'h0, 12'h0);
      idle(3);
      chk("single_data0", bus.data0, 12'hABC);
      chk("single_rom_addr", bus.rom_addr, 12'h401);

      // tie straight after reset
      do_reset();
      step(1, 1, 12'h010, 12'h000, 12'h020, 12'h000);
      idle(4);

      // sustained contention
      for (int k = 0; k < 6; k++)
         step(1, 1, 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
      idle(4);

      // address wrap
      step(1, 0, 12'hFFF, 12'h002, 12'h0, 12'h0);
      idle(3);
      chk("wrap_rom_addr", bus.rom_addr, 12'h001);

      // reset while requests are in flight
      step(1, 1, 12'h111, 12'h0, 12'h222, 12'h0);
      do_reset();
      idle(4);

      // stats check on the sustained-contention pattern from a clean start
      do_reset();
      for (int k = 0; k < 6; k++)
         step(1, 1, 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
      idle(3);
`ifdef SPRITE_FETCH_ARB_STATS_EN
      chk("alt_conflict_cnt", conflict_cnt, 6);
      chk("alt_gnt_sum", 32'(gnt_cnt0) + 32'(gnt_cnt1), m_gnt[0] + m_gnt[1]);
`endif

      // random traffic
      for (int k = 0; k < 400; k++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
      idle(4);
`ifdef SPRITE_FETCH_ARB_STATS_EN
      chk("gnt_cnt0", gnt_cnt0, 16'(m_gnt[0]));
      chk("gnt_cnt1", gnt_cnt1, 16'(m_gnt[1]));
      chk("conflict_cnt", conflict_cnt, 16'(m_conf));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
